// File: rtl/gray2bcd_rx.sv
// Gray-coded BCD digit receiver with a two-digit up/down position count.
// g is synchronized, decoded, step-checked against the last accepted digit.
module gray2bcd_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] g,
  input  logic       en,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       valid,
  output logic       up,
  output logic       down,
  output logic       jump_err,
  output logic       range_err
);

  logic [3:0] s1_q, s1_d;
  logic [3:0] s2_q, s2_d;
  logic [3:0] prev_g_q, prev_g_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       valid_q, valid_d;
  logic       up_q, up_d;
  logic       down_q, down_d;
  logic       jump_q, jump_d;
  logic       range_q, range_d;

  logic [3:0] val;
  logic [3:0] nxt_up;
  logic [3:0] nxt_dn;
  logic       evt;

  // Gray decode of the synchronized digit and the expected +/-1 neighbours.
  always_comb begin
    val[3] = s2_q[3];
    val[2] = val[3] ^ s2_q[2];
    val[1] = val[2] ^ s2_q[1];
    val[0] = val[1] ^ s2_q[0];
    nxt_up = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
    nxt_dn = (ones_q == 4'd0) ? 4'd9 : ones_q - 4'd1;
    evt    = en && (s2_q != prev_g_q);
  end

  // Next-state: synchronizer shift, event classification and count update.
  always_comb begin
    s1_d     = g;
    s2_d     = s1_q;
    prev_g_d = prev_g_q;
    ones_d   = ones_q;
    tens_d   = tens_q;
    valid_d  = 1'b0;
    up_d     = 1'b0;
    down_d   = 1'b0;
    jump_d   = 1'b0;
    range_d  = 1'b0;
    if (evt) begin
      unique case (1'b1)
        (val > 4'd9): begin
          range_d = 1'b1;
        end
        (val == nxt_up): begin
          up_d     = 1'b1;
          valid_d  = 1'b1;
          ones_d   = val;
          prev_g_d = s2_q;
          if (ones_q == 4'd9)
            tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
        end
        (val == nxt_dn): begin
          down_d   = 1'b1;
          valid_d  = 1'b1;
          ones_d   = val;
          prev_g_d = s2_q;
          if (ones_q == 4'd0)
            tens_d = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
        end
        default: begin
          jump_d   = 1'b1;
          valid_d  = 1'b1;
          ones_d   = val;
          prev_g_d = s2_q;
        end
      endcase
    end
  end

  // All state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 4'd0;
      s2_q     <= 4'd0;
      prev_g_q <= 4'd0;
      ones_q   <= 4'd0;
      tens_q   <= 4'd0;
      valid_q  <= 1'b0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      jump_q   <= 1'b0;
      range_q  <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      prev_g_q <= prev_g_d;
      ones_q   <= ones_d;
      tens_q   <= tens_d;
      valid_q  <= valid_d;
      up_q     <= up_d;
      down_q   <= down_d;
      jump_q   <= jump_d;
      range_q  <= range_d;
    end
  end

  assign ones      = ones_q;
  assign tens      = tens_q;
  assign valid     = valid_q;
  assign up        = up_q;
  assign down      = down_q;
  assign jump_err  = jump_q;
  assign range_err = range_q;

endmodule

// File: tb/tb_gray2bcd_rx.sv
// Bench for gray2bcd_rx: vector table, corner sequences, random moves.
// A position-count reference model is compared every cycle.
module tb_gray2bcd_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] g;
  logic       en;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       valid;
  logic       up;
  logic       down;
  logic       jump_err;
  logic       range_err;

  gray2bcd_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .g         (g),
    .en        (en),
    .ones      (ones),
    .tens      (tens),
    .valid     (valid),
    .up        (up),
    .down      (down),
    .jump_err  (jump_err),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gray_to_bin(input int gv);
    for (int i = 0; i < 16; i++)
      if ((i ^ (i >> 1)) == gv) return i;
    return 0;
  endfunction

  function automatic logic [3:0] bin_to_gray(input int v);
    return 4'(v ^ (v >> 1));
  endfunction

  // Reference: position 0..99, digit accepted in Gray form.
  int m_s1, m_s2, m_prev, m_pos;
  bit m_valid, m_up, m_down, m_jump, m_range;

  always @(posedge clk or negedge rst_n) begin : model
    automatic int v, cur, n_pos, n_prev;
    automatic bit nv, nu, nd, nj, nr;
    if (!rst_n) begin
      m_s1 <= 0; m_s2 <= 0; m_prev <= 0; m_pos <= 0;
      m_valid <= 0; m_up <= 0; m_down <= 0;
      m_jump <= 0; m_range <= 0;
    end else begin
      n_pos = m_pos; n_prev = m_prev;
      nv = 0; nu = 0; nd = 0; nj = 0; nr = 0;
      if (en && m_s2 != m_prev) begin
        v   = gray_to_bin(m_s2);
        cur = m_pos % 10;
        if (v > 9) nr = 1;
        else begin
          nv = 1;
          n_prev = m_s2;
          if (v == (cur + 1) % 10) begin
            nu = 1; n_pos = (m_pos + 1) % 100;
          end else if (v == (cur + 9) % 10) begin
            nd = 1; n_pos = (m_pos + 99) % 100;
          end else begin
            nj = 1; n_pos = m_pos - cur + v;
          end
        end
      end
      m_pos <= n_pos; m_prev <= n_prev;
      m_valid <= nv; m_up <= nu; m_down <= nd;
      m_jump <= nj; m_range <= nr;
      m_s2 <= m_s1;
      m_s1 <= int'(g);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ones", int'(ones), m_pos % 10);
      chk("tens", int'(tens), m_pos / 10);
      chk("valid", int'(valid), int'(m_valid));
      chk("up", int'(up), int'(m_up));
      chk("down", int'(down), int'(m_down));
      chk("jump_err", int'(jump_err), int'(m_jump));
      chk("range_err", int'(range_err), int'(m_range));
    end
  end

  typedef struct {
    logic [3:0] g;
    logic       en;
    int         hold;
    int         ones;
    int         tens;
  } vec_t;

  vec_t tbl [20];

  task automatic chk_zero(input string tag);
    chk({tag, "_ones"}, int'(ones), 0);
    chk({tag, "_tens"}, int'(tens), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_up"}, int'(up), 0);
    chk({tag, "_down"}, int'(down), 0);
    chk({tag, "_jump"}, int'(jump_err), 0);
    chk({tag, "_range"}, int'(range_err), 0);
  endtask

  initial begin
    tbl = '{
      '{4'b0001, 1'b1, 4, 1, 0},
      '{4'b0011, 1'b1, 4, 2, 0},
      '{4'b0010, 1'b1, 4, 3, 0},
      '{4'b0110, 1'b1, 4, 4, 0},
      '{4'b0111, 1'b1, 4, 5, 0},
      '{4'b0101, 1'b1, 4, 6, 0},
      '{4'b0100, 1'b1, 4, 7, 0},
      '{4'b1100, 1'b1, 4, 8, 0},
      '{4'b1101, 1'b1, 4, 9, 0},
      '{4'b0000, 1'b1, 4, 0, 1},
      '{4'b1101, 1'b1, 4, 9, 0},
      '{4'b0000, 1'b1, 4, 0, 1},
      '{4'b0001, 1'b1, 4, 1, 1},
      '{4'b0011, 1'b1, 4, 2, 1},
      '{4'b1111, 1'b1, 4, 2, 1},
      '{4'b0110, 1'b1, 4, 4, 1},
      '{4'b0000, 1'b1, 4, 0, 1},
      '{4'b0001, 1'b0, 4, 0, 1},
      '{4'b0010, 1'b0, 4, 0, 1},
      '{4'b0010, 1'b1, 4, 3, 1}
    };

    rst_n = 1'b0;
    g     = 4'b0000;
    en    = 1'b0;
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    en     = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      g  = tbl[i].g;
      en = tbl[i].en;
      repeat (tbl[i].hold) @(negedge clk);
      chk($sformatf("tbl%0d_ones", i), int'(ones), tbl[i].ones);
      chk($sformatf("tbl%0d_tens", i), int'(tens), tbl[i].tens);
    end

    // 00 -> 99 and 99 -> 00 wraps
    @(negedge clk);
    rst_n = 1'b0;
    g     = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    g     = 4'b1101;
    repeat (4) @(negedge clk);
    chk("wrap_dn_ones", int'(ones), 9);
    chk("wrap_dn_tens", int'(tens), 9);
    g = 4'b0000;
    repeat (4) @(negedge clk);
    chk("wrap_up_ones", int'(ones), 0);
    chk("wrap_up_tens", int'(tens), 0);

    // two-edge latency from a g change
    g = 4'b0001;
    @(negedge clk);
    chk("lat_k", int'(valid), 0);
    @(negedge clk);
    chk("lat_k1", int'(valid), 0);
    @(negedge clk);
    chk("lat_k2_valid", int'(valid), 1);
    chk("lat_k2_up", int'(up), 1);
    chk("lat_k2_ones", int'(ones), 1);

    // half-cycle async reset in the middle of a pending event
    g = 4'b0011;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    g     = 4'b0000;
    #1;
    chk_zero("async");
    #4;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_valid", int'(valid), 0);
    chk("post_rst_ones", int'(ones), 0);

    // random moves biased toward single steps
    for (int it = 0; it < 300; it++) begin
      automatic int cur, nxt, r;
      @(negedge clk);
      cur = m_pos % 10;
      r   = $urandom_range(0, 9);
      if (r < 4)      nxt = (cur + 1) % 10;
      else if (r < 7) nxt = (cur + 9) % 10;
      else            nxt = $urandom_range(0, 15);
      g  = bin_to_gray(nxt);
      en = ($urandom_range(0, 7) != 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/gray2bcd_rx.md
GRAY2BCD_RX -- requirements
Module: gray2bcd_rx

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low, ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 g  input  4  Gray-coded BCD digit {W,X,Y,Z}, W = MSB; asynchronous to clk.
REQ-005 en  input  1  synchronous enable for event processing.
REQ-006 ones  output  4  last accepted decoded BCD digit, 0..9.
REQ-007 tens  output  4  tens BCD digit of the position count, 0..9.
REQ-008 valid  output  1  one-cycle pulse when ones/tens were updated.
REQ-009 up, down  output  1 each  one-cycle direction pulses, qualified by valid.
REQ-010 jump_err  output  1  one-cycle pulse: accepted value was not a +/-1 step.
REQ-011 range_err  output  1  one-cycle pulse: decoded value 10..15 was rejected.

Function
REQ-012 g SHALL pass through a two-flop synchronizer (s1, s2) before any use.
REQ-013 Decode SHALL be combinational on s2: b3=W, b2=b3^X, b1=b2^Y, b0=b1^Z.
REQ-014 The block SHALL keep a registered last-accepted Gray value prev_g.
REQ-015 An event SHALL occur in a cycle where en=1 and s2 != prev_g; no event otherwise.
REQ-016 Latency: g stable before edge k -> s1 at k, s2 at k+1, outputs registered at edge k+2.
REQ-017 Event with decoded value 10..15: range_err=1; prev_g, ones, tens unchanged; valid, up, down, jump_err = 0.
REQ-018 Decoded value = ones+1, or 0 when ones=9: up=1, valid=1, ones<=value, prev_g<=s2.
REQ-019 Up-step 9->0 SHALL increment tens; tens 9 wraps to 0 (99 -> 00).
REQ-020 Decoded value = ones-1, or 9 when ones=0: down=1, valid=1, ones<=value, prev_g<=s2.
REQ-021 Down-step 0->9 SHALL decrement tens; tens 0 wraps to 9 (00 -> 99).
REQ-022 Any other in-range value: jump_err=1, valid=1, ones<=value, prev_g<=s2, tens unchanged, up=down=0.
REQ-023 Priority: range check first, then step check; up, down and jump_err are mutually exclusive.
REQ-024 All pulse outputs SHALL be 0 in every cycle without an event.
REQ-025 en=0: synchronizer keeps running, no events, all state held.
REQ-026 On en rising, the first s2 != prev_g SHALL be judged against the held ones, so a multi-step move while disabled gives jump_err.
REQ-027 The design SHALL have no combinational path from g or en to any output.

Reset
REQ-028 rst_n=0 SHALL immediately clear s1, s2, prev_g, ones, tens and all pulse outputs to 0, independent of clk.
REQ-029 Reset asserted mid-event SHALL discard the event; after release g=0000 produces no event.
REQ-030 Release SHALL take effect at the first rising clk with rst_n=1; no event is possible before two further edges.

Verification
REQ-031 Reset, en=1, g steps 0000->0001->0011->0010, each held 4 cycles -> three valid+up pulses; ones=1,2,3; tens=0.
REQ-032 Up 9->0: from ones=9 (g=1101), drive g=0000 -> valid, up, ones=0, tens+1; repeat from tens=9 -> tens=0.
REQ-033 Down from ones=0 tens=0: drive g=1101 -> valid, down, ones=9, tens=9.
REQ-034 From ones=2, drive g=1111 (value 10) -> range_err pulse only; ones stays 2; then g=0110 (4) -> jump_err, valid, ones=4.
REQ-035 Change g at edge k -> outputs update exactly at edge k+2; assert rst_n low for half a cycle mid-sequence -> all outputs 0 asynchronously.
REQ-036 en=0 while g moves 0001->0010, then en=1 -> one jump_err pulse, ones=3.
